// File: rtl/fpu_pkg.sv
// Shared FPU definitions: fsub pipeline latency, IEEE-754 single field
// positions, default tag width and a sign-manipulation helper.
package fpu_pkg;

    localparam int FSUB_LAT    = 3;
    localparam int FP_W        = 32;
    localparam int FP_SIGN_BIT = 31;
    localparam int FP_EXP_MSB  = 30;
    localparam int FP_EXP_LSB  = 23;
    localparam int FP_MAN_MSB  = 22;
    localparam int TAG_W_DEF   = 5;

    // Optionally invert the sign of a single-precision value; exponent and
    // mantissa pass through untouched, so this is exact for every encoding.
    function automatic logic [FP_W-1:0] fp_flip_sign(input logic [FP_W-1:0] x,
                                                     input logic            flip);
        return {x[FP_SIGN_BIT] ^ flip, x[FP_SIGN_BIT-1:0]};
    endfunction

endpackage

// File: rtl/fsub_result_fifo.sv
// Generic result FIFO with extended-width pointers. Push is never refused
// (the issuing side guarantees space); pop when empty is ignored. The head
// entry is read combinationally.
module fsub_result_fifo #(
    parameter int DEPTH = 8,
    parameter int W     = 37
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     push,
    input  logic [W-1:0]             push_data,
    input  logic                     pop,
    output logic [W-1:0]             head_data,
    output logic                     head_valid,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = $clog2(DEPTH);

    logic [AW:0]  wptr;
    logic [AW:0]  rptr;
    logic [W-1:0] mem [DEPTH];
    logic         pop_en;

    // Pointer difference is the occupancy; the extra MSB separates full from empty.
    assign count      = wptr - rptr;
    assign head_valid = (count != '0);
    assign pop_en     = pop && head_valid;
    assign head_data  = mem[rptr[AW-1:0]];

    // Pointer advance; both may move in the same cycle, leaving count unchanged.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wptr <= '0;
            rptr <= '0;
        end else begin
            if (push)   wptr <= wptr + 1'b1;
            if (pop_en) rptr <= rptr + 1'b1;
        end
    end

    // Storage write; contents are data only and are not cleared by reset.
    always_ff @(posedge clk) begin
        if (push) mem[wptr[AW-1:0]] <= push_data;
    end

endmodule

// File: rtl/fsub_issue.sv
// Issue/collect wrapper around the non-stallable fsub pipeline. Requests are
// turned into subtracts, tracked with a valid/tag shift pipe matched to the
// fsub latency, and their results collected into a FIFO. Issue is throttled
// by a credit count so that every in-flight result is guaranteed a slot.
module fsub_issue
    import fpu_pkg::*;
#(
    parameter int LAT   = FSUB_LAT,
    parameter int DEPTH = 8,
    parameter int TAG_W = TAG_W_DEF
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [31:0]      in_op1,
    input  logic [31:0]      in_op2,
    input  logic             in_sub,
    input  logic [TAG_W-1:0] in_tag,
    output logic [31:0]      fs_op1,
    output logic [31:0]      fs_op2,
    output logic             fs_reset,
    input  logic [31:0]      fs_result,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [31:0]      out_result,
    output logic [TAG_W-1:0] out_tag
);

    localparam int CW    = $clog2(DEPTH) + 1;
    localparam int OCC_W = $clog2(DEPTH + LAT + 1);

    logic                fire;
    logic [LAT-1:0]      vp;
    logic [TAG_W-1:0]    tp [LAT];
    logic [CW-1:0]       count;
    logic [OCC_W-1:0]    occ;
    logic [32+TAG_W-1:0] head;

    assign fire     = in_valid && in_ready;
    assign fs_reset = ~reset;

    // fsub only subtracts: an add is issued as A - (-B).
    assign fs_op1 = in_op1;
    assign fs_op2 = fp_flip_sign(in_op2, ~in_sub);

    // Valid pipe: one bit per fsub stage, cleared so stale results are never captured.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            vp <= '0;
        end else begin
            vp[0] <= fire;
            for (int i = 1; i < LAT; i++) vp[i] <= vp[i-1];
        end
    end

    // Tag pipe: data only, qualified by the valid pipe alongside it.
    always_ff @(posedge clk) begin
        tp[0] <= in_tag;
        for (int i = 1; i < LAT; i++) tp[i] <= tp[i-1];
    end

    // Credits in use: FIFO entries plus results still inside fsub.
    always_comb begin
        occ = OCC_W'(count);
        for (int i = 0; i < LAT; i++) occ = occ + OCC_W'(vp[i]);
    end

    // Ready depends only on registered state (and is held low during reset),
    // so there is no combinational path from out_ready or in_valid.
    assign in_ready = !reset && (occ < OCC_W'(DEPTH));

    fsub_result_fifo #(
        .DEPTH (DEPTH),
        .W     (32 + TAG_W)
    ) u_fifo (
        .clk        (clk),
        .reset      (reset),
        .push       (vp[LAT-1]),
        .push_data  ({fs_result, tp[LAT-1]}),
        .pop        (out_ready),
        .head_data  (head),
        .head_valid (out_valid),
        .count      (count)
    );

    assign out_result = head[32+TAG_W-1:TAG_W];
    assign out_tag    = head[TAG_W-1:0];

endmodule

// File: tb/tb_fsub_issue.sv
// Scoreboard bench for fsub_issue with a behavioural 3-cycle fsub model.
module tb_fsub_issue;

    localparam int TAG_W = 5;
    localparam logic [31:0] F1 = 32'h3F80_0000;   // 1.0
    localparam logic [31:0] F2 = 32'h4000_0000;   // 2.0
    localparam logic [31:0] F3 = 32'h4040_0000;   // 3.0

    logic             clk = 1'b0;
    logic             reset = 1'b1;
    logic             in_valid = 1'b0;
    logic             in_ready;
    logic [31:0]      in_op1 = '0;
    logic [31:0]      in_op2 = '0;
    logic             in_sub = 1'b0;
    logic [TAG_W-1:0] in_tag = '0;
    logic [31:0]      fs_op1;
    logic [31:0]      fs_op2;
    logic             fs_reset;
    logic [31:0]      fs_result;
    logic             out_valid;
    logic             out_ready = 1'b0;
    logic [31:0]      out_result;
    logic [TAG_W-1:0] out_tag;

    typedef struct packed {
        logic [31:0]      res;
        logic [TAG_W-1:0] tag;
    } exp_t;

    exp_t q[$];
    exp_t mon_e;
    int   n_cmp = 0;
    int   n_fail = 0;
    int   n_pop = 0;

    always #5 clk = ~clk;

    fsub_issue dut (
        .clk        (clk),
        .reset      (reset),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_op1     (in_op1),
        .in_op2     (in_op2),
        .in_sub     (in_sub),
        .in_tag     (in_tag),
        .fs_op1     (fs_op1),
        .fs_op2     (fs_op2),
        .fs_reset   (fs_reset),
        .fs_result  (fs_result),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_result (out_result),
        .out_tag    (out_tag)
    );

    function automatic real sp2real(input logic [31:0] x);
        if (x[30:0] == 31'd0) return 0.0;
        return $bitstoreal({x[31], 11'({3'b000, x[30:23]}) + 11'd896, x[22:0], 29'd0});
    endfunction

    function automatic logic [31:0] real2sp(input real r);
        logic [63:0] b;
        if (r == 0.0) return 32'h0;
        b = $realtobits(r);
        return {b[63], 8'(b[62:52] - 11'd896), b[51:29]};
    endfunction

    // Behavioural fsub: op1 - op2, three register stages, not stallable.
    logic [31:0] m1, m2, m3;
    always @(posedge clk) begin
        m1 <= real2sp(sp2real(fs_op1) - sp2real(fs_op2));
        m2 <= m1;
        m3 <= m2;
    end
    assign fs_result = m3;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_cmp++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %h, required %h", name, act, req);
        end
    endtask

    // Monitor: every accepted output is popped from the scoreboard and compared.
    always @(negedge clk) begin
        if (out_valid && out_ready) begin
            if (q.size() == 0) begin
                n_cmp++;
                n_fail++;
                $display("FAIL unexpected_out: got tag %0d result %h, required no output", out_tag, out_result);
            end else begin
                mon_e = q.pop_front();
                check("out_result", out_result, mon_e.res);
                check("out_tag", 32'(out_tag), 32'(mon_e.tag));
                n_pop++;
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time exceeded, required completion");
        $fatal(1, "watchdog");
    end

    task automatic cycle_drive(input logic v, input logic [31:0] a, input logic [31:0] b,
                               input logic s, input logic [TAG_W-1:0] t, output logic fired);
        @(posedge clk);
        #1;
        in_valid = v;
        in_op1   = a;
        in_op2   = b;
        in_sub   = s;
        in_tag   = t;
        @(negedge clk);
        fired = v && in_ready;
    endtask

    task automatic idle(input int n);
        logic f;
        for (int i = 0; i < n; i++) cycle_drive(1'b0, '0, '0, 1'b0, '0, f);
    endtask

    task automatic wait_drain();
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (q.size() == 0) break;
        end
        @(negedge clk);
        check("drain_left", 32'(q.size()), 32'd0);
    endtask

    task automatic single(input logic [31:0] a, input logic [31:0] b, input logic s,
                          input logic [TAG_W-1:0] t, input logic [31:0] res, input logic [31:0] op2_req);
        logic f;
        int   k;
        f = 1'b0;
        for (int i = 0; i < 20 && !f; i++) cycle_drive(1'b1, a, b, s, t, f);
        check("single_fire", 32'(f), 32'd1);
        if (f) q.push_back('{res: res, tag: t});
        check("fs_op2", fs_op2, op2_req);
        check("fs_op1", fs_op1, a);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        k = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            k++;
            if (out_valid) break;
        end
        check("latency", 32'(k), 32'd4);
    endtask

    initial begin
        logic f;
        int   acc;
        int   holes;
        int   drops;
        int   pops0;
        int   seen;

        // Reset held
        @(negedge clk);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_in_ready", 32'(in_ready), 32'd0);
        check("rst_fs_reset", 32'(fs_reset), 32'd0);
        @(posedge clk);
        #1;
        reset = 1'b0;
        @(negedge clk);
        check("post_rst_in_ready", 32'(in_ready), 32'd1);
        check("post_rst_fs_reset", 32'(fs_reset), 32'd1);
        out_ready = 1'b1;

        // Single subtract and single add
        single(F2, F1, 1'b1, 5'd3, F1, F1);
        wait_drain();
        single(F2, F1, 1'b0, 5'd7, F3, 32'hBF80_0000);
        wait_drain();

        // Back-pressure: consumer stalled, back-to-back issue
        out_ready = 1'b0;
        acc = 0;
        pops0 = n_pop;
        for (int i = 0; i < 20; i++) begin
            cycle_drive(1'b1, real2sp(real'(acc + 2)), F1, 1'b1, TAG_W'(acc), f);
            if (f) begin
                q.push_back('{res: real2sp(real'(acc + 1)), tag: TAG_W'(acc)});
                acc++;
            end
        end
        check("bp_accepts", 32'(acc), 32'd8);
        check("bp_in_ready", 32'(in_ready), 32'd0);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        out_ready = 1'b1;
        wait_drain();
        check("bp_pops", 32'(n_pop - pops0), 32'd8);
        idle(2);
        check("bp_empty", 32'(out_valid), 32'd0);

        // Streaming: 100 consecutive requests, consumer always ready
        holes = 0;
        drops = 0;
        for (int k = 0; k < 105; k++) begin
            if (k < 100) begin
                cycle_drive(1'b1, real2sp(real'(k + 3)), F1, (k % 2) == 1, TAG_W'(k), f);
                if (f) q.push_back('{res: real2sp(real'((k % 2) == 1 ? k + 2 : k + 4)), tag: TAG_W'(k)});
                else drops++;
            end else begin
                cycle_drive(1'b0, '0, '0, 1'b0, '0, f);
            end
            if (k >= 4 && k <= 103 && !out_valid) holes++;
        end
        check("stream_drops", 32'(drops), 32'd0);
        check("stream_holes", 32'(holes), 32'd0);
        wait_drain();

        // Pop while captures are still landing into a FIFO at full credit
        out_ready = 1'b0;
        acc = 0;
        for (int i = 0; i < 20 && acc < 8; i++) begin
            cycle_drive(1'b1, real2sp(real'(acc + 10)), F2, 1'b0, TAG_W'(acc + 8), f);
            if (f) begin
                q.push_back('{res: real2sp(real'(acc + 12)), tag: TAG_W'(acc + 8)});
                acc++;
            end
        end
        check("full_accepts", 32'(acc), 32'd8);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        check("full_pop_valid", 32'(out_valid), 32'd1);
        check("full_pop_in_ready", 32'(in_ready), 32'd0);
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        @(negedge clk);
        check("credit_returned", 32'(in_ready), 32'd1);
        cycle_drive(1'b1, F3, F1, 1'b1, 5'd16, f);
        check("credit_fire", 32'(f), 32'd1);
        if (f) q.push_back('{res: F2, tag: 5'd16});
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        out_ready = 1'b1;
        wait_drain();

        // Reset mid-flight: three accepted requests are dropped
        for (int i = 0; i < 3; i++) cycle_drive(1'b1, F3, F1, 1'b1, TAG_W'(20 + i), f);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        #2;
        reset = 1'b1;
        @(negedge clk);
        check("mid_rst_out_valid", 32'(out_valid), 32'd0);
        check("mid_rst_in_ready", 32'(in_ready), 32'd0);
        @(posedge clk);
        #3;
        reset = 1'b0;
        seen = 0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (out_valid) seen++;
        end
        check("stale_results", 32'(seen), 32'd0);
        single(F3, F1, 1'b1, 5'd9, F2, F1);
        wait_drain();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/fsub_issue.md
# fsub_issue

Issue and collect stage around the fixed-latency `fsub` pipeline. Accepts add/subtract requests over a valid/ready handshake and converts add to subtract by flipping the sign of op2. Tracks in-flight operations with a valid/tag shift pipe matched to `fsub` latency, and captures results into a credit-protected FIFO. `fsub` cannot stall, so this block enforces back-pressure on the issuing side. It sits between the core's FPU dispatch and writeback.

## Interface
- `LAT`, 3: `fsub` latency in cycles, from operands presented to result visible.
- `DEPTH`, 8: result FIFO entries; power of two, ≥ LAT+2.
- `TAG_W`, 5: request tag width (destination register id).

Ports:
- `clk`  in  1  single clock.
- `reset`  in  1  asynchronous, active-high.
- `in_valid`  in  1  request valid.
- `in_ready`  out  1  request accepted when `in_valid && in_ready`.
- `in_op1`  in  32  IEEE-754 single operand A.
- `in_op2`  in  32  IEEE-754 single operand B.
- `in_sub`  in  1  1: A−B, 0: A+B.
- `in_tag`  in  TAG_W  returned with the result.
- `fs_op1`  out  32  to `fsub` op1.
- `fs_op2`  out  32  to `fsub` op2.
- `fs_reset`  out  1  to `fsub` reset (active-low), equals `~reset`.
- `fs_result`  in  32  from `fsub` result.
- `out_valid`  out  1  FIFO head valid.
- `out_ready`  in  1  consumer pops when `out_valid && out_ready`.
- `out_result`  out  32  FIFO head result.
- `out_tag`  out  TAG_W  FIFO head tag.

## Operation
- `fire = in_valid && in_ready`.
- `fs_op1 = in_op1`, combinational.
- `fs_op2 = {in_op2[31] ^ ~in_sub, in_op2[30:0]}`, combinational.
- `fsub` runs every cycle. Non-fire cycles produce garbage that is never captured.
- Valid pipe `vp[0..LAT-1]` and tag pipe `tp[0..LAT-1]`:
  - `vp[0] <= fire`, `tp[0] <= in_tag`.
  - Each cycle, shift by one.
- Capture: when `vp[LAT-1]` is set, `fs_result` and `tp[LAT-1]` are the matching result and tag. On that cycle, `{fs_result, tp[LAT-1]}` is written to `fifo[wptr]` and `wptr` increments.
- Pop: when `out_valid && out_ready`, `rptr` increments.
- Pointers are log2(DEPTH)+1 bits; wrap is natural.
  - `count = wptr - rptr`.
  - `out_valid = (count != 0)`.
  - `out_result`/`out_tag` = `fifo[rptr]`, combinational read.
- Credit rule: `occ = count + popcount(vp)`; `in_ready = (occ < DEPTH)`.
  - Registered-state only; no combinational path from `out_ready` or `in_valid`.
  - Guarantees the FIFO never overflows.
- Simultaneous push and pop: both pointers advance and count is unchanged. Legal in every state, including full.
- Pop when empty is ignored. Push is never blocked because the credit rule guarantees space.
- Throughput: with `out_ready` held at 1, one request per cycle is sustained (requires DEPTH ≥ LAT+2).

## Timing
- Accept in cycle t. The result is captured at the edge ending cycle t+LAT, and `out_valid`/`out_result` are visible in cycle t+LAT+1. Total latency: LAT+1 = 4 cycles.
- Results leave in issue order.
- Reset asserted, asynchronously and at any time:
  - `vp` cleared, `wptr` = `rptr` = 0.
  - `out_valid` = 0, `in_ready` = 0 while reset is held.
  - `out_result`/`out_tag` are don't-care; FIFO storage is not reset.
  - In-flight operations are dropped.
- After reset deasserts: `in_ready` = 1 from the first cycle.
- `fsub` is held in reset via `fs_reset`. Any stale results it produces are ignored because `vp` is clear.

## Structure
- Shared package `fpu_pkg`: `FSUB_LAT` = 3, float field constants (sign bit 31), and tag width default. This block takes `LAT` from `FSUB_LAT`.
- One natural sub-module: `fsub_result_fifo`, a generic DEPTH×(32+TAG_W) FIFO with pointer/count logic.
- The valid/tag pipe and credit logic stay in `fsub_issue`.
- `fsub` itself is instantiated by the parent, not inside this block.

## Test plan
- Single sub: op1=0x40000000, op2=0x3F800000, in_sub=1, tag=3 → `out_valid` exactly 4 cycles later with result 0x3F800000, tag 3.
- Single add: same operands, in_sub=0, tag=7 → result 0x40400000, tag 7, 4 cycles later. Check `fs_op2` = 0xBF800000 during the accept cycle.
- Back-pressure: `out_ready`=0, issue back-to-back → exactly 8 accepts, then `in_ready`=0. Raise `out_ready` → 8 results in tag order 0..7, no loss or duplicate.
- Streaming: `out_ready`=1, 100 consecutive requests → `in_ready` never drops, one result per cycle after the 4-cycle fill, order preserved.
- Simultaneous push/pop at full: fill to 8 entries, then pop while a capture lands → count stays 8 and data order is intact.
- Reset mid-flight: accept 3 requests, assert `reset` for one cycle → `out_valid` stays 0 and no stale result appears. The first post-reset request returns correctly after 4 cycles.
